// File: rtl/mmio_router.sv
// MMIO router: fans one host read channel and one host write channel out to
// NUM_DEVICES downstream ports, decoding the device from the top index bits.
package tia_mmio_pkg;
  localparam int TIA_MMIO_INDEX_WIDTH = 18;
  localparam int TIA_MMIO_DATA_WIDTH  = 16;
endpackage

module mmio_router #(
  parameter int NUM_DEVICES    = 4,
  parameter int INDEX_WIDTH    = tia_mmio_pkg::TIA_MMIO_INDEX_WIDTH,
  parameter int DATA_WIDTH     = tia_mmio_pkg::TIA_MMIO_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA = '1,
  localparam int SEL_WIDTH     = $clog2(NUM_DEVICES),
  localparam int LOCAL_WIDTH   = INDEX_WIDTH - SEL_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              host_read_req,
  input  logic [INDEX_WIDTH-1:0]            host_read_index,
  output logic                              host_read_ack,
  output logic [DATA_WIDTH-1:0]             host_read_data,
  input  logic                              host_write_req,
  input  logic [INDEX_WIDTH-1:0]            host_write_index,
  input  logic [DATA_WIDTH-1:0]             host_write_data,
  output logic                              host_write_ack,
  output logic [NUM_DEVICES-1:0]            dev_read_req,
  output logic [NUM_DEVICES*LOCAL_WIDTH-1:0] dev_read_index,
  input  logic [NUM_DEVICES-1:0]            dev_read_ack,
  input  logic [NUM_DEVICES*DATA_WIDTH-1:0] dev_read_data,
  output logic [NUM_DEVICES-1:0]            dev_write_req,
  output logic [NUM_DEVICES*LOCAL_WIDTH-1:0] dev_write_index,
  output logic [NUM_DEVICES*DATA_WIDTH-1:0] dev_write_data,
  input  logic [NUM_DEVICES-1:0]            dev_write_ack,
  output logic                              read_error,
  output logic                              write_error,
  input  logic                              error_clear
);

  // state   | meaning
  // IDLE    | waiting for host req, captures select/index/data
  // FORWARD | selected dev req asserted, counting down to timeout
  // RESPOND | host ack pulse and response data registered this cycle
  // DRAIN   | waiting for host req to drop before accepting again
  typedef enum logic [1:0] {IDLE, FORWARD, RESPOND, DRAIN} state_t;

  localparam logic [SEL_WIDTH:0] NUM_DEV_L = NUM_DEVICES[SEL_WIDTH:0];
  localparam logic [15:0]        TMO_L     = 16'(TIMEOUT_CYCLES - 1);

  // Channel 0 is the read channel, channel 1 the write channel.
  state_t                  state_q    [2];
  state_t                  state_d    [2];
  logic [SEL_WIDTH-1:0]    sel_q      [2];
  logic [LOCAL_WIDTH-1:0]  local_q    [2];
  logic                    err_q      [2];
  logic [NUM_DEVICES-1:0]  dev_req_q  [2];
  logic                    host_ack_q [2];
  logic                    flag_q     [2];
  logic [15:0]             tmr_q      [2];

  logic                    host_req_w [2];
  logic [INDEX_WIDTH-1:0]  host_idx_w [2];
  logic [NUM_DEVICES-1:0]  dev_ack_w  [2];
  logic [SEL_WIDTH-1:0]    sel_in     [2];
  logic [LOCAL_WIDTH-1:0]  local_in   [2];
  logic                    in_range   [2];
  logic                    ack_hit    [2];
  logic                    tmo        [2];
  logic [NUM_DEVICES-1:0]  sel_onehot [2];

  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   cap_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   rd_sel;

  assign host_req_w[0] = host_read_req;
  assign host_req_w[1] = host_write_req;
  assign host_idx_w[0] = host_read_index;
  assign host_idx_w[1] = host_write_index;
  assign dev_ack_w[0]  = dev_read_ack;
  assign dev_ack_w[1]  = dev_write_ack;

  for (genvar c = 0; c < 2; c++) begin : g_chan
    assign sel_in[c]     = host_idx_w[c][INDEX_WIDTH-1 -: SEL_WIDTH];
    assign local_in[c]   = host_idx_w[c][LOCAL_WIDTH-1:0];
    assign in_range[c]   = {1'b0, sel_in[c]} < NUM_DEV_L;
    // Masking with our own registered req drops stray or late acks.
    assign ack_hit[c]    = |(dev_ack_w[c] & dev_req_q[c]);
    assign tmo[c]        = (tmr_q[c] == 16'd0) && !ack_hit[c];
    assign sel_onehot[c] = {{(NUM_DEVICES-1){1'b0}}, 1'b1} << sel_q[c];
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        IDLE:    if (host_req_w[c]) state_d[c] = in_range[c] ? FORWARD : RESPOND;
        FORWARD: if (ack_hit[c] || tmo[c]) state_d[c] = RESPOND;
        RESPOND: state_d[c] = DRAIN;
        DRAIN:   if (!host_req_w[c]) state_d[c] = IDLE;
        default: state_d[c] = IDLE;
      endcase
    end
    rd_sel = '0;
    for (int d = 0; d < NUM_DEVICES; d++) begin
      if (dev_req_q[0][d]) rd_sel = dev_read_data[d*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (!reset_n) begin
        state_q[c]    <= IDLE;
        sel_q[c]      <= '0;
        local_q[c]    <= '0;
        err_q[c]      <= 1'b0;
        dev_req_q[c]  <= '0;
        host_ack_q[c] <= 1'b0;
        flag_q[c]     <= 1'b0;
        tmr_q[c]      <= '0;
      end else begin
        state_q[c]    <= state_d[c];
        host_ack_q[c] <= (state_q[c] == RESPOND);
        dev_req_q[c]  <= (state_q[c] == FORWARD && state_d[c] == FORWARD) ? sel_onehot[c] : '0;
        if (state_q[c] == IDLE && host_req_w[c]) begin
          sel_q[c]   <= sel_in[c];
          local_q[c] <= local_in[c];
          err_q[c]   <= !in_range[c];
          tmr_q[c]   <= TMO_L;
        end else if (state_q[c] == FORWARD) begin
          if (tmo[c])                err_q[c] <= 1'b1;
          else if (tmr_q[c] != 16'd0) tmr_q[c] <= tmr_q[c] - 16'd1;
        end
        // A new error wins over a coincident clear.
        if (state_q[c] == RESPOND && err_q[c]) flag_q[c] <= 1'b1;
        else if (error_clear)                  flag_q[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q[1] == IDLE && host_write_req)  wdata_q <= host_write_data;
      if (state_q[0] == FORWARD && ack_hit[0])   cap_q   <= rd_sel;
      if (state_q[0] == RESPOND)                 rdata_q <= err_q[0] ? ERROR_DATA : cap_q;
    end
  end

  assign host_read_ack   = host_ack_q[0];
  assign host_write_ack  = host_ack_q[1];
  assign host_read_data  = rdata_q;
  assign dev_read_req    = dev_req_q[0];
  assign dev_write_req   = dev_req_q[1];
  assign dev_read_index  = {NUM_DEVICES{local_q[0]}};
  assign dev_write_index = {NUM_DEVICES{local_q[1]}};
  assign dev_write_data  = {NUM_DEVICES{wdata_q}};
  assign read_error      = flag_q[0];
  assign write_error     = flag_q[1];

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: a 4-device instance with an 8-cycle timeout
// and a 3-device instance for out-of-range selects.
module tb_mmio_router;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        host_read_req = 0, host_write_req = 0, error_clear = 0;
  logic [17:0] host_read_index = '0, host_write_index = '0;
  logic [15:0] host_write_data = '0;
  logic        host_read_ack, host_write_ack, read_error, write_error;
  logic [15:0] host_read_data;
  logic [3:0]  dev_read_req, dev_write_req;
  logic [3:0]  dev_read_ack = '0, dev_write_ack = '0;
  logic [63:0] dev_read_index, dev_write_index, dev_write_data;
  logic [63:0] dev_read_data = '0;

  logic        t3_read_req = 0, t3_write_req = 0, t3_error_clear = 0;
  logic [17:0] t3_read_index = '0, t3_write_index = '0;
  logic [15:0] t3_write_data = '0;
  logic        t3_read_ack, t3_write_ack, t3_read_error, t3_write_error;
  logic [15:0] t3_read_data;
  logic [2:0]  t3_dev_read_req, t3_dev_write_req;
  logic [2:0]  t3_dev_read_ack = '0, t3_dev_write_ack = '0;
  logic [47:0] t3_dev_read_index, t3_dev_write_index, t3_dev_write_data;
  logic [47:0] t3_dev_read_data = '0;

  mmio_router #(.NUM_DEVICES(4), .TIMEOUT_CYCLES(8)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .host_read_req(host_read_req), .host_read_index(host_read_index),
    .host_read_ack(host_read_ack), .host_read_data(host_read_data),
    .host_write_req(host_write_req), .host_write_index(host_write_index),
    .host_write_data(host_write_data), .host_write_ack(host_write_ack),
    .dev_read_req(dev_read_req), .dev_read_index(dev_read_index),
    .dev_read_ack(dev_read_ack), .dev_read_data(dev_read_data),
    .dev_write_req(dev_write_req), .dev_write_index(dev_write_index),
    .dev_write_data(dev_write_data), .dev_write_ack(dev_write_ack),
    .read_error(read_error), .write_error(write_error), .error_clear(error_clear)
  );

  mmio_router #(.NUM_DEVICES(3)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .host_read_req(t3_read_req), .host_read_index(t3_read_index),
    .host_read_ack(t3_read_ack), .host_read_data(t3_read_data),
    .host_write_req(t3_write_req), .host_write_index(t3_write_index),
    .host_write_data(t3_write_data), .host_write_ack(t3_write_ack),
    .dev_read_req(t3_dev_read_req), .dev_read_index(t3_dev_read_index),
    .dev_read_ack(t3_dev_read_ack), .dev_read_data(t3_dev_read_data),
    .dev_write_req(t3_dev_write_req), .dev_write_index(t3_dev_write_index),
    .dev_write_data(t3_dev_write_data), .dev_write_ack(t3_dev_write_ack),
    .read_error(t3_read_error), .write_error(t3_write_error), .error_clear(t3_error_clear)
  );

  int checks = 0;
  int failures = 0;
  int rd_acks = 0;
  int wr_acks = 0;

  always @(negedge clock) begin
    if (host_read_ack)  rd_acks++;
    if (host_write_ack) wr_acks++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [17:0] idx;
    int          sel;
    int          delay;  // -1: device never acks
    logic [15:0] data;
    logic [3:0]  req;
    logic [15:0] lidx;
    logic [15:0] rdata;
    logic        flag;
  } rvec_t;

  rvec_t vecs [6];

  task automatic rd_txn(input rvec_t v);
    int n;
    int a0;
    int bad;
    a0 = rd_acks;
    bad = 0;
    host_read_index = v.idx;
    host_read_req = 1'b1;
    n = 0;
    while (dev_read_req == '0 && n < 20) begin tick(); n++; end
    check("rd_latency", n, 2);
    check("rd_dev_req", dev_read_req, v.req);
    check("rd_local_index", dev_read_index[v.sel*16 +: 16], v.lidx);
    if (v.delay < 0) begin
      n = 0;
      while (dev_read_req != '0 && n < 50) begin tick(); n++; end
      check("rd_timeout_req_cycles", n, 7);
    end else begin
      repeat (v.delay) tick();
      check("rd_req_held", dev_read_req, v.req);
      dev_read_ack[v.sel] = 1'b1;
      dev_read_data[v.sel*16 +: 16] = v.data;
      tick();
      dev_read_ack = '0;
      dev_read_data = '0;
      check("rd_req_drop", dev_read_req, 4'b0000);
    end
    check("rd_ack_not_early", host_read_ack, 1'b0);
    tick();
    check("rd_ack", host_read_ack, 1'b1);
    check("rd_data", host_read_data, v.rdata);
    check("rd_error_flag", read_error, v.flag);
    // Host keeps req high for 5 cycles; a late device ack is thrown in too.
    for (int i = 0; i < 5; i++) begin
      if (i == 1) dev_read_ack[v.sel] = 1'b1;
      if (i == 2) dev_read_ack = '0;
      tick();
      if (dev_read_req != '0 || host_read_data !== v.rdata) bad++;
    end
    check("rd_drain_quiet", bad, 0);
    host_read_req = 1'b0;
    tick();
    tick();
    check("rd_single_ack", rd_acks - a0, 1);
  endtask

  initial begin
    vecs[0] = '{18'h1_0004, 1,  3, 16'hCAFE, 4'b0010, 16'h0004, 16'hCAFE, 1'b0};
    vecs[1] = '{18'h0_0000, 0,  0, 16'h1111, 4'b0001, 16'h0000, 16'h1111, 1'b0};
    vecs[2] = '{18'h3_FFFF, 3,  5, 16'hA5A5, 4'b1000, 16'hFFFF, 16'hA5A5, 1'b0};
    vecs[3] = '{18'h2_00AA, 2, -1, 16'h0000, 4'b0100, 16'h00AA, 16'hFFFF, 1'b1};
    vecs[4] = '{18'h1_0100, 1,  2, 16'h5A5A, 4'b0010, 16'h0100, 16'h5A5A, 1'b1};
    vecs[5] = '{18'h2_1234, 2,  1, 16'h0000, 4'b0100, 16'h1234, 16'h0000, 1'b1};

    tick();
    tick();
    check("rst_dev_read_req", dev_read_req, 4'b0000);
    check("rst_dev_write_req", dev_write_req, 4'b0000);
    check("rst_host_acks", {host_read_ack, host_write_ack}, 2'b00);
    check("rst_read_data", host_read_data, 16'h0000);
    check("rst_errors", {read_error, write_error}, 2'b00);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) rd_txn(vecs[i]);

    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("err_clear_read", read_error, 1'b0);

    // Concurrent write to device 3 and read from device 0.
    begin
      int r0, w0;
      r0 = rd_acks;
      w0 = wr_acks;
      host_read_index = 18'h0_0040;
      host_read_req = 1'b1;
      host_write_index = 18'h3_0010;
      host_write_data = 16'h1234;
      host_write_req = 1'b1;
      tick();
      tick();
      check("cc_dev_read_req", dev_read_req, 4'b0001);
      check("cc_dev_write_req", dev_write_req, 4'b1000);
      check("cc_write_data", dev_write_data[48 +: 16], 16'h1234);
      check("cc_write_index", dev_write_index[48 +: 16], 16'h0010);
      check("cc_read_index", dev_read_index[0 +: 16], 16'h0040);
      dev_write_ack[3] = 1'b1;
      tick();
      dev_write_ack = '0;
      check("cc_write_req_drop", dev_write_req, 4'b0000);
      check("cc_read_req_held", dev_read_req, 4'b0001);
      tick();
      check("cc_host_write_ack", host_write_ack, 1'b1);
      check("cc_no_read_ack_yet", host_read_ack, 1'b0);
      host_write_req = 1'b0;
      dev_read_ack[0] = 1'b1;
      dev_read_data[15:0] = 16'hBEEF;
      tick();
      dev_read_ack = '0;
      dev_read_data = '0;
      tick();
      check("cc_host_read_ack", host_read_ack, 1'b1);
      check("cc_read_data", host_read_data, 16'hBEEF);
      host_read_req = 1'b0;
      repeat (3) tick();
      check("cc_read_ack_count", rd_acks - r0, 1);
      check("cc_write_ack_count", wr_acks - w0, 1);
      check("cc_no_errors", {read_error, write_error}, 2'b00);
    end

    // Reset while a read sits in FORWARD.
    begin
      int a0;
      host_read_index = 18'h2_0001;
      host_read_req = 1'b1;
      tick();
      tick();
      check("rstmid_dev_req", dev_read_req, 4'b0100);
      reset_n = 1'b0;
      host_read_req = 1'b0;
      a0 = rd_acks;
      tick();
      check("rstmid_dev_req_drop", dev_read_req, 4'b0000);
      check("rstmid_no_ack", host_read_ack, 1'b0);
      check("rstmid_read_data", host_read_data, 16'h0000);
      reset_n = 1'b1;
      repeat (4) tick();
      check("rstmid_no_late_ack", rd_acks - a0, 0);
      check("rstmid_idle_req", dev_read_req, 4'b0000);
    end

    // Out-of-range select on the 3-device instance.
    t3_read_index = 18'h3_0000;
    t3_read_req = 1'b1;
    tick();
    check("oor_rd_no_req_1", t3_dev_read_req, 3'b000);
    check("oor_rd_ack_early", t3_read_ack, 1'b0);
    tick();
    check("oor_rd_ack", t3_read_ack, 1'b1);
    check("oor_rd_data", t3_read_data, 16'hFFFF);
    check("oor_rd_error", t3_read_error, 1'b1);
    check("oor_rd_no_req_2", t3_dev_read_req, 3'b000);
    t3_read_req = 1'b0;
    tick();

    // Write error set while error_clear is held: the new error wins.
    t3_write_index = 18'h3_0005;
    t3_write_data = 16'h7777;
    t3_write_req = 1'b1;
    t3_error_clear = 1'b1;
    tick();
    check("oor_wr_no_req", t3_dev_write_req, 3'b000);
    tick();
    check("oor_wr_ack", t3_write_ack, 1'b1);
    check("oor_wr_error_vs_clear", t3_write_error, 1'b1);
    check("oor_rd_error_cleared", t3_read_error, 1'b0);
    t3_error_clear = 1'b0;
    t3_write_req = 1'b0;
    tick();
    check("oor_wr_error_sticky", t3_write_error, 1'b1);
    t3_error_clear = 1'b1;
    tick();
    t3_error_clear = 1'b0;
    check("oor_wr_error_cleared", t3_write_error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
